interpolador_cuadrante: RTL and testbench

INTERPOLADOR_CUADRANTE -- requirements
Module: interpolador_cuadrante

---
 rtl/interpolador_cuadrante.sv | 229 ++++++++++++++++++++++
 tb/tb_interpolador_cuadrante.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/interpolador_cuadrante.sv
// -----------------------------------------------------------------------------
// interpolador_cuadrante
//
// Purpose: takes one 64x64 quadrant of a 256x256 RGB888 source image held in a
// ROM and writes a 2x bilinear upscale (128x128 RGB888) into a destination RAM.
// Every output pixel costs 6 cycles: 4 ROM reads (neighbours A, B, C, D), one
// cycle to catch the last read, and one write cycle.
//
// Ports:
//   clk        single clock
//   reset      synchronous active-high reset
//   start      level; launches one frame when sampled high in IDLE
//   pos_cursor quadrant select, [1:0]=column, [3:2]=row, sampled at launch
//   rom_addr   source address row*256+col (holds its value outside FETCH)
//   rom_data   source pixel {R,G,B}, valid one cycle after rom_addr
//   ram_addr   destination address y*128+x
//   ram_wdata  interpolated pixel {R,G,B}
//   ram_we     one-cycle write strobe
//   busy       high from the cycle after launch through the last write
//   done       one-cycle pulse the cycle after the last write
// -----------------------------------------------------------------------------
module interpolador_cuadrante (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  pos_cursor,
   output logic [15:0] rom_addr,
   input  logic [23:0] rom_data,
   output logic [13:0] ram_addr,
   output logic [23:0] ram_wdata,
   output logic        ram_we,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_WRITE,
      S_DONE
   } state_t;

   state_t      state_q,    state_d;
   logic [1:0]  phase_q,    phase_d;    // which neighbour is on rom_addr in FETCH
   logic [6:0]  x_q,        x_d;
   logic [6:0]  y_q,        y_d;
   logic [3:0]  quad_q,     quad_d;
   logic [15:0] rom_addr_q, rom_addr_d;
   logic [23:0] pix_a_q,    pix_a_d;
   logic [23:0] pix_b_q,    pix_b_d;
   logic [23:0] pix_c_q,    pix_c_d;
   logic [23:0] pix_d_q,    pix_d_d;

   // ---------------------------------------------------------------------------
   // Neighbour address generation. Phase bit 0 selects the right-hand column,
   // bit 1 the lower row, giving A, B, C, D for phases 0..3. The +1 neighbour
   // clamps at 63 so reads never leave the quadrant.
   // ---------------------------------------------------------------------------
   logic [5:0]  src_i, src_j, src_i_nxt, src_j_nxt;
   logic [5:0]  col_sel, row_sel;
   logic [15:0] fetch_addr;

   always_comb begin
      src_i      = x_q[6:1];
      src_j      = y_q[6:1];
      src_i_nxt  = (src_i == 6'd63) ? src_i : src_i + 6'd1;
      src_j_nxt  = (src_j == 6'd63) ? src_j : src_j + 6'd1;
      col_sel    = phase_q[0] ? src_i_nxt : src_i;
      row_sel    = phase_q[1] ? src_j_nxt : src_j;
      // Quadrant origin is a multiple of 64, so row/col are plain concatenations.
      fetch_addr = {quad_q[3:2], row_sel, quad_q[1:0], col_sel};
   end

   // ---------------------------------------------------------------------------
   // Per-channel interpolation. Sums are widened by one/two bits and then
   // truncated by the shift, so no rounding is applied.
   // ---------------------------------------------------------------------------
   function automatic logic [7:0] interp_ch(
      input logic [7:0] a,
      input logic [7:0] b,
      input logic [7:0] c,
      input logic [7:0] d,
      input logic       x_odd,
      input logic       y_odd
   );
      logic [8:0] sum_h;
      logic [8:0] sum_v;
      logic [9:0] sum_4;
      sum_h = {1'b0, a} + {1'b0, b};
      sum_v = {1'b0, a} + {1'b0, c};
      sum_4 = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
      case ({y_odd, x_odd})
         2'b00:   interp_ch = a;
         2'b01:   interp_ch = sum_h[8:1];
         2'b10:   interp_ch = sum_v[8:1];
         default: interp_ch = sum_4[9:2];
      endcase
   endfunction

   logic [23:0] interp_pix;

   always_comb begin
      interp_pix = '0;
      for (int ch = 0; ch < 3; ch++) begin
         interp_pix[ch*8 +: 8] = interp_ch(pix_a_q[ch*8 +: 8], pix_b_q[ch*8 +: 8],
                                           pix_c_q[ch*8 +: 8], pix_d_q[ch*8 +: 8],
                                           x_q[0], y_q[0]);
      end
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its _d signal regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         phase_q    <= '0;
         x_q        <= '0;
         y_q        <= '0;
         quad_q     <= '0;
         rom_addr_q <= '0;
         pix_a_q    <= '0;
         pix_b_q    <= '0;
         pix_c_q    <= '0;
         pix_d_q    <= '0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         x_q        <= x_d;
         y_q        <= y_d;
         quad_q     <= quad_d;
         rom_addr_q <= rom_addr_d;
         pix_a_q    <= pix_a_d;
         pix_b_q    <= pix_b_d;
         pix_c_q    <= pix_c_d;
         pix_d_q    <= pix_d_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path through
      // the case statement can leave one unassigned and infer a latch.
      state_d    = state_q;
      phase_d    = phase_q;
      x_d        = x_q;
      y_d        = y_q;
      quad_d     = quad_q;
      rom_addr_d = rom_addr_q;
      pix_a_d    = pix_a_q;
      pix_b_d    = pix_b_q;
      pix_c_d    = pix_c_q;
      pix_d_d    = pix_d_q;
      rom_addr   = rom_addr_q;
      ram_we     = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               quad_d  = pos_cursor;
               x_d     = '0;
               y_d     = '0;
               phase_d = '0;
               state_d = S_FETCH;
            end
         end

         S_FETCH: begin
            busy       = 1'b1;
            rom_addr   = fetch_addr;
            rom_addr_d = fetch_addr;
            // Data for the previous phase's address arrives this cycle.
            case (phase_q)
               2'd1:    pix_a_d = rom_data;
               2'd2:    pix_b_d = rom_data;
               2'd3:    pix_c_d = rom_data;
               default: ;
            endcase
            phase_d = phase_q + 2'd1;
            if (phase_q == 2'd3) begin
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            busy    = 1'b1;
            pix_d_d = rom_data;
            state_d = S_WRITE;
         end

         S_WRITE: begin
            busy   = 1'b1;
            ram_we = 1'b1;
            if (x_q == 7'd127 && y_q == 7'd127) begin
               state_d = S_DONE;
            end else begin
               // x wraps naturally from 127 to 0 in 7 bits.
               x_d = x_q + 7'd1;
               if (x_q == 7'd127) begin
                  y_d = y_q + 7'd1;
               end
               phase_d = '0;
               state_d = S_FETCH;
            end
         end

         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Write port is forced to zero outside WRITE so reset leaves it clean.
   assign ram_addr  = ram_we ? {y_q, x_q} : '0;
   assign ram_wdata = ram_we ? interp_pix : '0;

endmodule

// File: tb/tb_interpolador_cuadrante.sv
// -----------------------------------------------------------------------------
// tb_interpolador_cuadrante
//
// Self-checking bench for interpolador_cuadrante. A ROM array answers reads
// with one cycle of latency, a RAM array records writes, and a reference
// function computes each expected output pixel directly from the source image
// using integer arithmetic on the quadrant-relative neighbours.
// -----------------------------------------------------------------------------
module tb_interpolador_cuadrante;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  pos_cursor;
   logic [15:0] rom_addr;
   logic [23:0] rom_data;
   logic [13:0] ram_addr;
   logic [23:0] ram_wdata;
   logic        ram_we;
   logic        busy;
   logic        done;

   interpolador_cuadrante dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .pos_cursor (pos_cursor),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_we     (ram_we),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Source image and destination image models.
   logic [23:0] mem   [65536];
   logic [23:0] ram_m [16384];
   int          ram_gen [16384];

   int          frame_id = 0;
   logic [3:0]  exp_quad = 4'd0;
   int          we_cnt   = 0;
   int          done_cnt = 0;
   int          quad_err = 0;

   int          errors = 0;
   int          checks = 0;

   always @(posedge clk) begin
      rom_data <= mem[rom_addr];
   end

   always @(posedge clk) begin
      if (ram_we) begin
         ram_m[ram_addr]   <= ram_wdata;
         ram_gen[ram_addr] <= frame_id;
         we_cnt            <= we_cnt + 1;
      end
      if (done) begin
         done_cnt <= done_cnt + 1;
      end
      if (busy && (rom_addr[15:14] != exp_quad[3:2] || rom_addr[7:6] != exp_quad[1:0])) begin
         quad_err <= quad_err + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected output pixel (x,y) for a quadrant at origin (qx,qy).
   function automatic logic [23:0] model_pix(input int x, input int y, input int qx, input int qy);
      int          i, j, i2, j2, va, vb, vc, vd, r;
      logic [23:0] a, b, c, d, res;
      i  = x / 2;
      j  = y / 2;
      i2 = (i + 1 > 63) ? 63 : i + 1;
      j2 = (j + 1 > 63) ? 63 : j + 1;
      a  = mem[(qy + j)  * 256 + qx + i];
      b  = mem[(qy + j)  * 256 + qx + i2];
      c  = mem[(qy + j2) * 256 + qx + i];
      d  = mem[(qy + j2) * 256 + qx + i2];
      res = '0;
      for (int ch = 0; ch < 3; ch++) begin
         va = int'(a[ch*8 +: 8]);
         vb = int'(b[ch*8 +: 8]);
         vc = int'(c[ch*8 +: 8]);
         vd = int'(d[ch*8 +: 8]);
         if (x % 2 == 0 && y % 2 == 0)      r = va;
         else if (x % 2 == 1 && y % 2 == 0) r = (va + vb) / 2;
         else if (x % 2 == 0)               r = (va + vc) / 2;
         else                               r = (va + vb + vc + vd) / 4;
         res[ch*8 +: 8] = 8'(r);
      end
      return res;
   endfunction

   function automatic logic [23:0] written(input int a);
      return (ram_gen[a] == frame_id) ? ram_m[a] : 24'hxxxxxx;
   endfunction

   int we_base, done_base, quad_base;

   task automatic launch(input logic [3:0] cur);
      logic [15:0] first;
      frame_id++;
      exp_quad   = cur;
      pos_cursor = cur;
      we_base    = we_cnt;
      done_base  = done_cnt;
      quad_base  = quad_err;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      first      = {cur[3:2], 6'd0, cur[1:0], 6'd0};
      check("first_rom_addr", 32'(rom_addr), 32'(first));
      check("busy_after_launch", 32'(busy), 32'd1);
   endtask

   task automatic run_writes(input int n);
      int budget;
      budget = 6 * n + 50;
      while (we_cnt - we_base < n && budget > 0) begin
         tick();
         budget--;
      end
      check("writes_reached", 32'(we_cnt - we_base >= n), 32'd1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      int          n;
      int          qx, qy;
      int          snap;
      logic [23:0] px;

      reset      = 1'b1;
      start      = 1'b0;
      pos_cursor = 4'd0;
      for (int a = 0; a < 16384; a++) ram_gen[a] = 0;
      for (int a = 0; a < 65536; a++) mem[a] = 24'd0;
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Reset state
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_done",      32'(done),      32'd0);
      check("rst_ram_we",    32'(ram_we),    32'd0);
      check("rst_rom_addr",  32'(rom_addr),  32'd0);
      check("rst_ram_addr",  32'(ram_addr),  32'd0);
      check("rst_ram_wdata", 32'(ram_wdata), 32'd0);

      // Column ramp, quadrant 0: first row of output
      for (int a = 0; a < 65536; a++) mem[a] = {3{a[7:0]}};
      launch(4'd0);
      run_writes(128);
      check("ramp_ram0",   32'(written(0)),   32'h000000);
      check("ramp_ram1",   32'(written(1)),   32'h000000);
      check("ramp_ram2",   32'(written(2)),   32'h010101);
      check("ramp_ram127", 32'(written(127)), 32'h3F3F3F);
      for (int a = 0; a < 128; a++) begin
         check($sformatf("ramp_pix%0d", a), 32'(written(a)), 32'(model_pix(a % 128, a / 128, 0, 0)));
      end
      do_reset();

      // Row ramp in red, quadrant (64,64)
      for (int a = 0; a < 65536; a++) mem[a] = {a[15:8], 16'h0000};
      launch(4'b0101);
      run_writes(129);
      px = written(128);
      check("row_ram128_r", 32'(px[23:16]), 32'd64);
      check("row_ram0",     32'(written(0)), 32'h400000);
      do_reset();

      // Four-corner blend at the origin
      for (int a = 0; a < 65536; a++) mem[a] = 24'($urandom);
      mem[0]   = 24'hFFFFFF;
      mem[1]   = 24'h000000;
      mem[256] = 24'h000000;
      mem[257] = 24'h010101;
      launch(4'd0);
      run_writes(130);
      check("blend_ram0",   32'(written(0)),   32'hFFFFFF);
      check("blend_ram1",   32'(written(1)),   32'h7F7F7F);
      check("blend_ram128", 32'(written(128)), 32'h7F7F7F);
      check("blend_ram129", 32'(written(129)), 32'h404040);
      do_reset();

      // Reset mid-frame, together with start to confirm reset priority
      launch(4'($urandom_range(0, 15)));
      for (int k = 0; k < 498; k++) tick();
      reset = 1'b1;
      start = 1'b1;
      tick();
      reset = 1'b0;
      start = 1'b0;
      check("abort_busy",   32'(busy),   32'd0);
      check("abort_done",   32'(done),   32'd0);
      check("abort_ram_we", 32'(ram_we), 32'd0);
      snap = we_cnt;
      for (int k = 0; k < 60; k++) tick();
      check("abort_no_writes", 32'(we_cnt - snap), 32'd0);
      check("abort_still_idle", 32'(busy), 32'd0);

      // Full frame: random image and quadrant, with start/pos_cursor noise
      for (int a = 0; a < 65536; a++) mem[a] = 24'($urandom);
      launch(4'($urandom_range(0, 15)));
      qx = int'(exp_quad[1:0]) * 64;
      qy = int'(exp_quad[3:2]) * 64;
      n  = 1;
      while (done !== 1'b1 && n < 99000) begin
         if (n < 97000 && n % 997 == 13) begin
            start      = 1'($urandom);
            pos_cursor = 4'($urandom);
         end
         if (n >= 97000) start = 1'b0;
         tick();
         n++;
      end
      start = 1'b0;
      check("frame_done_latency", 32'(n), 32'd98305);
      check("frame_busy_at_done", 32'(busy), 32'd0);
      check("frame_write_count", 32'(we_cnt - we_base), 32'd16384);
      check("frame_quad_reads", 32'(quad_err - quad_base), 32'd0);
      for (int a = 0; a < 16384; a++) begin
         check($sformatf("frame_pix%0d", a), 32'(written(a)), 32'(model_pix(a % 128, a / 128, qx, qy)));
      end
      for (int k = 0; k < 10; k++) tick();
      check("frame_done_pulses", 32'(done_cnt - done_base), 32'd1);
      check("frame_idle_busy",   32'(busy), 32'd0);
      check("frame_idle_done",   32'(done), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
